// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } pc_state_e;

  localparam int unsigned CNT_W = 4;

  // One bit of the lane mask: lane is live when at or above the entry offset.
  function automatic logic lane_mask_bit(input int unsigned lane, input int unsigned lo);
    return lane >= lo;
  endfunction

endpackage

// File: rtl/pc_mask_gen.sv
// Per-lane valid mask for a fetch group entered at an unaligned offset.
module pc_mask_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned FETCH_W = 8,
  parameter int unsigned LG      = $clog2(FETCH_W)
) (
  input  logic [LG-1:0]      lo,
  input  logic               valid,
  output logic [FETCH_W-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      mask[i] = valid & lane_mask_bit(i, int'(lo));
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, stall hold, flush with bubble.
// Optional predictor redirect is enabled with `define PC_PRED_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       FETCH_W      = 8,
  parameter int unsigned       N_STALL      = 3,
  parameter int unsigned       FLUSH_BUBBLE = 1,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_STALL-1:0] stall_in,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_addr,
  input  logic               pred_redir,
  input  logic [ADDR_W-1:0]  pred_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_valid,
  output logic [FETCH_W-1:0] fetch_mask
);

  localparam int unsigned       LG       = $clog2(FETCH_W);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(FETCH_W);
  localparam logic [CNT_W-1:0]  CNT_INIT = (FLUSH_BUBBLE == 0) ? '0 : CNT_W'(FLUSH_BUBBLE - 1);

  pc_state_e          state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [ADDR_W-1:0]  pc_next;
  logic               valid_next;
  logic [FETCH_W-1:0] mask_next;
  logic               advance;
  logic               pred_take;

`ifdef PC_PRED_EN
  assign pred_take = pred_redir;
`else
  logic unused_pred;
  assign pred_take   = 1'b0;
  assign unused_pred = ^{pred_redir, pred_addr};
`endif

  assign advance = (state == RUN) && (stall_in == '0);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pc_next    = pc;
    if (flush) begin
      pc_next = flush_addr;
      if (FLUSH_BUBBLE != 0) begin
        state_next = BUBBLE;
        cnt_next   = CNT_INIT;
      end else begin
        state_next = RUN;
        cnt_next   = '0;
      end
    end else begin
      case (state)
        IDLE: state_next = RUN;
        RUN: begin
          if (pred_take && advance) begin
            pc_next = pred_addr;
          end else if (advance) begin
            pc_next = (pc & ~(STEP - 1'b1)) + STEP;
          end
        end
        BUBBLE: begin
          if (cnt == '0) state_next = RUN;
          else           cnt_next   = cnt - 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Valid and mask are derived from the next-state values so they register with pc.
  assign valid_next = (state_next == RUN);

  pc_mask_gen #(
    .FETCH_W (FETCH_W),
    .LG      (LG)
  ) u_mask (
    .lo    (pc_next[LG-1:0]),
    .valid (valid_next),
    .mask  (mask_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_mask  <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pc          <= pc_next;
      fetch_valid <= valid_next;
      fetch_mask  <= mask_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: scoreboarded cycle model plus directed checks.
module tb_pc_gen;

`ifdef PC_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_BUB  = 2;
  localparam int BUB_TB = 1;

  typedef struct {
    logic [7:0] pc;
    logic       valid;
    logic [7:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with default bubble length
  logic       rst = 1'b0;
  logic [2:0] stall_in = '0;
  logic       flush = 1'b0;
  logic [7:0] flush_addr = '0;
  logic       pred_redir = 1'b0;
  logic [7:0] pred_addr = '0;
  logic [7:0] pc;
  logic       fetch_valid;
  logic [7:0] fetch_mask;

  // DUT with a three-cycle bubble
  logic       rst3 = 1'b0;
  logic [2:0] stall3 = '0;
  logic       flush3 = 1'b0;
  logic [7:0] faddr3 = '0;
  logic       pred3 = 1'b0;
  logic [7:0] paddr3 = '0;
  logic [7:0] pc3;
  logic       v3;
  logic [7:0] m3;

  pc_gen #(.ADDR_W(8), .FETCH_W(8), .N_STALL(3), .FLUSH_BUBBLE(1), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .flush_addr(flush_addr),
    .pred_redir(pred_redir), .pred_addr(pred_addr),
    .pc(pc), .fetch_valid(fetch_valid), .fetch_mask(fetch_mask)
  );

  pc_gen #(.ADDR_W(8), .FETCH_W(8), .N_STALL(3), .FLUSH_BUBBLE(3), .RESET_PC(8'h00)) dut3 (
    .clk(clk), .rst(rst3), .stall_in(stall3), .flush(flush3), .flush_addr(faddr3),
    .pred_redir(pred3), .pred_addr(paddr3),
    .pc(pc3), .fetch_valid(v3), .fetch_mask(m3)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  int         m_state = M_IDLE;
  logic [7:0] m_pc    = '0;
  int         m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the default DUT, advance the model, compare after the edge.
  task automatic step(input logic r, input logic [2:0] st, input logic fl, input logic [7:0] fa,
                      input logic pr, input logic [7:0] pa);
    exp_t e;
    rst = r; stall_in = st; flush = fl; flush_addr = fa; pred_redir = pr; pred_addr = pa;
    if (!r) begin
      m_state = M_IDLE; m_pc = 8'h00; m_cnt = 0;
    end else if (fl) begin
      m_pc = fa;
      if (BUB_TB == 0) m_state = M_RUN;
      else begin m_state = M_BUB; m_cnt = BUB_TB - 1; end
    end else begin
      case (m_state)
        M_IDLE: m_state = M_RUN;
        M_RUN: if (st == 3'b000) begin
          if (pr && PRED_EN) m_pc = pa;
          else               m_pc = {m_pc[7:3], 3'b000} + 8'd8;
        end
        default: if (m_cnt == 0) m_state = M_RUN; else m_cnt--;
      endcase
    end
    e.pc    = m_pc;
    e.valid = (m_state == M_RUN);
    e.mask  = '0;
    for (int i = 0; i < 8; i++) if (e.valid && i >= int'(m_pc[2:0])) e.mask[i] = 1'b1;
    sb.push_back(e);
    tick();
    cyc++;
    e = sb.pop_front();
    check($sformatf("pc@%0d", cyc), 32'(pc), 32'(e.pc));
    check($sformatf("valid@%0d", cyc), 32'(fetch_valid), 32'(e.valid));
    check($sformatf("mask@%0d", cyc), 32'(fetch_mask), 32'(e.mask));
  endtask

  task automatic idle_step(input logic [2:0] st);
    step(1'b1, st, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    // reset and startup
    step(1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 8'h00);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_valid", 32'(fetch_valid), 32'h0);
    check("rst_mask", 32'(fetch_mask), 32'h00);
    idle_step(3'b000);
    check("start_pc", 32'(pc), 32'h00);
    check("start_mask", 32'(fetch_mask), 32'hFF);
    idle_step(3'b000);
    check("seq1", 32'(pc), 32'h08);
    idle_step(3'b000);
    check("seq2", 32'(pc), 32'h10);

    // stall hold
    for (int i = 0; i < 3; i++) begin
      idle_step(3'b010);
      check("stall_hold", 32'(pc), 32'h10);
      check("stall_valid", 32'(fetch_valid), 32'h1);
    end
    idle_step(3'b000);
    check("stall_release", 32'(pc), 32'h18);

    // flush under full stall
    step(1'b1, 3'b111, 1'b1, 8'h2B, 1'b0, 8'h00);
    check("flush_pc", 32'(pc), 32'h2B);
    check("flush_bubble", 32'(fetch_valid), 32'h0);
    idle_step(3'b111);
    check("flush_valid", 32'(fetch_valid), 32'h1);
    check("flush_mask", 32'(fetch_mask), 32'hF8);
    idle_step(3'b111);
    check("flush_stall_hold", 32'(pc), 32'h2B);
    idle_step(3'b000);
    check("flush_next", 32'(pc), 32'h30);
    check("flush_next_mask", 32'(fetch_mask), 32'hFF);

    // flush during bubble restarts
    step(1'b1, 3'b000, 1'b1, 8'h40, 1'b0, 8'h00);
    step(1'b1, 3'b000, 1'b1, 8'h57, 1'b0, 8'h00);
    check("reflush_pc", 32'(pc), 32'h57);
    check("reflush_valid", 32'(fetch_valid), 32'h0);
    idle_step(3'b000);
    check("reflush_mask", 32'(fetch_mask), 32'h80);

    // wrap
    step(1'b1, 3'b000, 1'b1, 8'hF8, 1'b0, 8'h00);
    idle_step(3'b000);
    idle_step(3'b000);
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_valid", 32'(fetch_valid), 32'h1);
    check("wrap_mask", 32'(fetch_mask), 32'hFF);

    // predictor
    step(1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 8'h45);
`ifdef PC_PRED_EN
    check("pred_pc", 32'(pc), 32'h45);
    check("pred_mask", 32'(fetch_mask), 32'hE0);
`else
    check("pred_ignored_pc", 32'(pc), 32'h08);
    check("pred_ignored_mask", 32'(fetch_mask), 32'hFF);
`endif
    check("pred_valid", 32'(fetch_valid), 32'h1);
    step(1'b1, 3'b000, 1'b1, 8'h80, 1'b1, 8'h45);
    check("pred_vs_flush_pc", 32'(pc), 32'h80);
    check("pred_vs_flush_valid", 32'(fetch_valid), 32'h0);
    step(1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 8'h45);
    check("pred_in_bubble", 32'(pc), 32'h80);
    step(1'b1, 3'b100, 1'b0, 8'h00, 1'b1, 8'h45);
    check("pred_stalled", 32'(pc), 32'h80);
    idle_step(3'b000);
    check("pred_after_stall", 32'(pc), 32'h88);

    // random traffic through the scoreboard
    for (int i = 0; i < 400; i++) begin
      logic       r, fl, pr;
      logic [2:0] st;
      r  = ($urandom_range(0, 40) != 0);
      st = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      fl = ($urandom_range(0, 7) == 0);
      pr = ($urandom_range(0, 3) == 0);
      step(r, st, fl, 8'($urandom), pr, 8'($urandom));
    end

    // three-cycle bubble, then reset in the middle of a bubble
    rst3 = 1'b0; tick(); tick();
    rst3 = 1'b1; tick();
    check("b3_start", 32'(v3), 32'h1);
    flush3 = 1'b1; faddr3 = 8'h60; tick();
    flush3 = 1'b0;
    check("b3_pc", 32'(pc3), 32'h60);
    for (int i = 0; i < 2; i++) begin
      check("b3_low", 32'(v3), 32'h0);
      tick();
    end
    check("b3_low_last", 32'(v3), 32'h0);
    check("b3_mask_low", 32'(m3), 32'h00);
    tick();
    check("b3_high", 32'(v3), 32'h1);
    check("b3_mask", 32'(m3), 32'hFF);
    check("b3_pc_hold", 32'(pc3), 32'h60);

    flush3 = 1'b1; faddr3 = 8'h60; tick();
    flush3 = 1'b0; tick();
    check("mid_bub_valid", 32'(v3), 32'h0);
    rst3 = 1'b0; tick();
    rst3 = 1'b1;
    check("mid_rst_pc", 32'(pc3), 32'h00);
    check("mid_rst_valid", 32'(v3), 32'h0);
    check("mid_rst_mask", 32'(m3), 32'h00);
    tick();
    check("mid_rst_run", 32'(v3), 32'h1);
    check("mid_rst_run_pc", 32'(pc3), 32'h00);
    tick();
    check("mid_rst_seq", 32'(pc3), 32'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
